// File: rtl/vending_machine.sv
// Two-product coin vending controller with 10-then-5 change return.
// Optional build macro COIN_RETURN_EN adds a cancel input that refunds the full credit.
module vending_machine #(
  parameter int PRICE_1    = 15,
  parameter int PRICE_2    = 25,
  parameter int MAX_CREDIT = 50,
  parameter int CW         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_5,
  input  logic coin_10,
  input  logic select_1,
  input  logic select_2,
`ifdef COIN_RETURN_EN
  input  logic cancel,
`endif
  output logic dispense_1,
  output logic dispense_2,
  output logic change_5,
  output logic change_10
);

  // state  | meaning
  // IDLE   | accepting coins and selections
  // CHANGE | paying out credit, one coin per cycle; inputs ignored
  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [CW-1:0] P1    = CW'(PRICE_1);
  localparam logic [CW-1:0] P2    = CW'(PRICE_2);
  localparam logic [CW:0]   MAXC  = (CW+1)'(MAX_CREDIT);
  localparam logic [CW-1:0] FIVE  = CW'(5);
  localparam logic [CW-1:0] TEN   = CW'(10);

  state_t        state;
  logic [CW-1:0] credit;
  logic          coin_5_prev, coin_10_prev, select_1_prev, select_2_prev;
  logic          ev_c5, ev_c10, ev_s1, ev_s2, ev_cancel;
  logic [CW-1:0] coin_add;
  logic [CW:0]   coin_sum;
  logic [CW-1:0] credit_eff;

`ifdef COIN_RETURN_EN
  logic cancel_prev;
  assign ev_cancel = cancel & ~cancel_prev;
`else
  assign ev_cancel = 1'b0;
`endif

  always_comb begin
    ev_c5    = coin_5 & ~coin_5_prev;
    ev_c10   = coin_10 & ~coin_10_prev;
    ev_s1    = select_1 & ~select_1_prev;
    ev_s2    = select_2 & ~select_2_prev;
    coin_add = (ev_c5 ? FIVE : '0) + (ev_c10 ? TEN : '0);
    coin_sum = {1'b0, credit} + {1'b0, coin_add};
    // an over-ceiling cycle rejects every coin in it, not just the excess
    credit_eff = (coin_sum > MAXC) ? credit : coin_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      credit        <= '0;
      coin_5_prev   <= 1'b0;
      coin_10_prev  <= 1'b0;
      select_1_prev <= 1'b0;
      select_2_prev <= 1'b0;
`ifdef COIN_RETURN_EN
      cancel_prev   <= 1'b0;
`endif
      dispense_1    <= 1'b0;
      dispense_2    <= 1'b0;
      change_5      <= 1'b0;
      change_10     <= 1'b0;
    end else begin
      coin_5_prev   <= coin_5;
      coin_10_prev  <= coin_10;
      select_1_prev <= select_1;
      select_2_prev <= select_2;
`ifdef COIN_RETURN_EN
      cancel_prev   <= cancel;
`endif
      dispense_1    <= 1'b0;
      dispense_2    <= 1'b0;
      change_5      <= 1'b0;
      change_10     <= 1'b0;
      case (state)
        IDLE: begin
          credit <= credit_eff;
          if (ev_s1) begin
            if (credit_eff >= P1) begin
              dispense_1 <= 1'b1;
              credit     <= credit_eff - P1;
              state      <= (credit_eff != P1) ? CHANGE : IDLE;
            end
          end else if (ev_s2) begin
            if (credit_eff >= P2) begin
              dispense_2 <= 1'b1;
              credit     <= credit_eff - P2;
              state      <= (credit_eff != P2) ? CHANGE : IDLE;
            end
          end else if (ev_cancel && credit_eff != '0) begin
            state <= CHANGE;
          end
        end
        CHANGE: begin
          if (credit >= TEN) begin
            change_10 <= 1'b1;
            credit    <= credit - TEN;
            if (credit == TEN) state <= IDLE;
          end else begin
            change_5 <= 1'b1;
            credit   <= credit - FIVE;
            if (credit == FIVE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed, table-driven bench for vending_machine; adds a cancel sequence when
// COIN_RETURN_EN is defined.
module tb_vending_machine;

  logic clk = 1'b0;
  logic reset;
  logic coin_5, coin_10, select_1, select_2;
  logic dispense_1, dispense_2, change_5, change_10;
`ifdef COIN_RETURN_EN
  logic cancel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_machine dut (
    .clk       (clk),
    .reset     (reset),
    .coin_5    (coin_5),
    .coin_10   (coin_10),
    .select_1  (select_1),
    .select_2  (select_2),
`ifdef COIN_RETURN_EN
    .cancel    (cancel),
`endif
    .dispense_1(dispense_1),
    .dispense_2(dispense_2),
    .change_5  (change_5),
    .change_10 (change_10)
  );

  // in  = {coin_5, coin_10, select_1, select_2}
  // out = {dispense_1, dispense_2, change_5, change_10}
  typedef struct {
    logic [3:0] in_bits;
    logic [3:0] exp_bits;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic [3:0] in_bits, input logic [3:0] exp_bits);
    vec_t r;
    r.in_bits  = in_bits;
    r.exp_bits = exp_bits;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [3:0] exp_bits);
    logic [3:0] act;
    act = {dispense_1, dispense_2, change_5, change_10};
    checks++;
    if (act !== exp_bits) begin
      errors++;
      $display("FAIL %s: got d1d2c5c10=%b expected %b", name, act, exp_bits);
    end
  endtask

  task automatic step(input logic [3:0] in_bits, input logic [3:0] exp_bits, input string name);
    {coin_5, coin_10, select_1, select_2} = in_bits;
    @(posedge clk);
    #1;
    check(name, exp_bits);
  endtask

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] C5   = 4'b1000;
  localparam logic [3:0] C10  = 4'b0100;
  localparam logic [3:0] S1   = 4'b0010;
  localparam logic [3:0] S2   = 4'b0001;
  localparam logic [3:0] D1   = 4'b1000;
  localparam logic [3:0] D2   = 4'b0100;
  localparam logic [3:0] CH5  = 4'b0010;
  localparam logic [3:0] CH10 = 4'b0001;

  initial begin
    reset = 1'b0;
    {coin_5, coin_10, select_1, select_2} = '0;
`ifdef COIN_RETURN_EN
    cancel = 1'b0;
`endif

    // select with no credit
    v(S1, NONE); v(NONE, NONE);
    // 5 + 10, select_1 -> exact vend, then credit is empty
    v(C5, NONE); v(C10, NONE); v(S1, D1); v(NONE, NONE);
    v(S1, NONE); v(NONE, NONE);
    // 20, select_1 -> change 5
    v(C10, NONE); v(NONE, NONE); v(C10, NONE); v(S1, D1); v(NONE, CH5); v(NONE, NONE);
    // 30, select_2 -> change 5
    v(C10, NONE); v(NONE, NONE); v(C10, NONE); v(NONE, NONE); v(C10, NONE);
    v(S2, D2); v(NONE, CH5); v(NONE, NONE);
    // 50, select_1 -> 10,10,10,5
    for (int i = 0; i < 5; i++) begin v(C10, NONE); v(NONE, NONE); end
    v(S1, D1); v(NONE, CH10); v(NONE, CH10); v(NONE, CH10); v(NONE, CH5); v(NONE, NONE);
    // both coins in one cycle, then select_1
    v(C5 | C10, NONE); v(S1, D1); v(NONE, NONE);
    // credit 25, both selects -> product 1 wins, change 10
    v(C10, NONE); v(NONE, NONE); v(C10, NONE); v(C5, NONE);
    v(S1 | S2, D1); v(NONE, CH10); v(NONE, NONE);
    v(S2, NONE); v(NONE, NONE);
    // coin held 5 cycles counts once (10 < 15), then +5 reaches 15
    for (int i = 0; i < 5; i++) v(C10, NONE);
    v(NONE, NONE); v(S1, NONE); v(C5, NONE); v(S1, D1); v(NONE, NONE);
    // coin and select in the same cycle
    v(C10, NONE); v(C5 | S1, D1); v(NONE, NONE);
    // coin at 50 rejected; 50-25 -> 10,10,5
    for (int i = 0; i < 5; i++) begin v(C10, NONE); v(NONE, NONE); end
    v(C10, NONE); v(NONE, NONE);
    v(S2, D2); v(NONE, CH10); v(NONE, CH10); v(NONE, CH5); v(NONE, NONE);
    // coin during change is not credited
    v(C10, NONE); v(NONE, NONE); v(C10, NONE); v(S1, D1);
    v(C10, CH5); v(NONE, NONE); v(C5, NONE); v(S1, NONE); v(NONE, NONE);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", NONE);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].in_bits, vecs[i].exp_bits, $sformatf("vec%0d", i));

    // reset in the middle of a change sequence drops remaining change
    for (int i = 0; i < 5; i++) begin
      step(C10, NONE, "mid_rst_coin"); step(NONE, NONE, "mid_rst_gap");
    end
    step(S1, D1, "mid_rst_vend");
    step(NONE, CH10, "mid_rst_ch10");
    reset = 1'b0;
    step(NONE, NONE, "mid_rst_assert");
    reset = 1'b1;
    step(NONE, NONE, "mid_rst_after0");
    step(NONE, NONE, "mid_rst_after1");
    step(S1, NONE, "mid_rst_no_credit");
    step(NONE, NONE, "mid_rst_idle");

`ifdef COIN_RETURN_EN
    // cancel with no credit does nothing
    cancel = 1'b1;
    step(NONE, NONE, "cancel_empty");
    cancel = 1'b0;
    step(NONE, NONE, "cancel_empty_idle");
    // 15 refunded as 10 then 5
    step(C10, NONE, "cancel_c10");
    step(C5, NONE, "cancel_c5");
    cancel = 1'b1;
    step(NONE, NONE, "cancel_event");
    cancel = 1'b0;
    step(NONE, CH10, "cancel_ch10");
    step(NONE, CH5, "cancel_ch5");
    step(NONE, NONE, "cancel_done");
    // select outranks cancel in the same cycle
    step(C10, NONE, "cancel_pri_c10");
    step(NONE, NONE, "cancel_pri_gap");
    step(C10, NONE, "cancel_pri_c10b");
    cancel = 1'b1;
    step(S1, D1, "cancel_pri_vend");
    cancel = 1'b0;
    step(NONE, CH5, "cancel_pri_ch5");
    step(NONE, NONE, "cancel_pri_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
